// File: rtl/bomba_pkg.sv
// Shared types, fault codes and helper functions for the N-pump tank-fill controller.
package bomba_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    BOMBEO = 2'd1,
    ESPERA = 2'd2,
    FALLA  = 2'd3
  } estado_t;

  // Fault codes reported on codigo_o.
  localparam logic [1:0] COD_NINGUNO  = 2'b00;
  localparam logic [1:0] COD_INVALIDO = 2'b01;
  localparam logic [1:0] COD_SECO     = 2'b10;

  // True when the low n bits of palabra are a contiguous run of 1s starting at bit 0.
  function automatic logic es_termometro(input logic [31:0] palabra, input int n);
    logic visto_cero;
    logic ok;
    visto_cero = 1'b0;
    ok         = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        if (!palabra[i]) visto_cero = 1'b1;
        else if (visto_cero) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Number of asserted bits among the low n bits of palabra.
  function automatic int unsigned popcount(input logic [31:0] palabra, input int n);
    int unsigned cuenta;
    cuenta = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < n && palabra[i]) cuenta++;
    end
    return cuenta;
  endfunction

  // Largest of three integers, used to size the shared timer width.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sensor_filtro.sv
// Level-sensor front end: 2-flop synchroniser, debounce and thermometer validity check.
// The accepted word, its validity and its level all update together, 2 + DEB_CYC
// cycles after a pin change. DEB_CYC must be at least 2.
module sensor_filtro
  import bomba_pkg::*;
#(
  parameter int N_NIV   = 3,
  parameter int DEB_CYC = 4,
  parameter int CNT_W   = 7
) (
  input  logic                       ck,
  input  logic                       rst_i,
  input  logic [N_NIV-1:0]           i_sensores,
  output logic [N_NIV-1:0]           o_palabra,
  output logic                       o_valida,
  output logic [$clog2(N_NIV+1)-1:0] o_nivel
);

  localparam int NW = $clog2(N_NIV + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYC);
  localparam logic [CNT_W-1:0] DEB_ULT = CNT_W'(DEB_CYC - 1);

  logic [N_NIV-1:0] r_sinc1;
  logic [N_NIV-1:0] r_sinc2;
  logic [N_NIV-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [N_NIV-1:0] r_palabra;
  logic             r_valida;
  logic [NW-1:0]    r_nivel;
  logic             w_acepta;

  // Candidate has been stable long enough; this is its last counted cycle.
  assign w_acepta = (r_sinc2 == r_cand) && (r_cnt == DEB_ULT);

  // Two-flop synchroniser for the asynchronous sensor pins.
  // NOTE: every flop, including the synchroniser, is on the async reset so the
  // whole front end starts from a known all-zero (valid, empty tank) picture.
  always_ff @(posedge ck or negedge rst_i) begin
    if (!rst_i) begin
      r_sinc1 <= '0;
      r_sinc2 <= '0;
    end else begin
      // NOTE: non-blocking so r_sinc2 takes the old r_sinc1, forming two stages.
      r_sinc1 <= i_sensores;
      r_sinc2 <= r_sinc1;
    end
  end

  // Debounce: restart the stability count on any change, saturate once stable.
  always_ff @(posedge ck or negedge rst_i) begin
    if (!rst_i) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (r_sinc2 != r_cand) begin
      r_cand <= r_sinc2;
      r_cnt  <= CNT_W'(1);
    end else if (r_cnt != DEB_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Accepted word with its validity and level, registered together.
  always_ff @(posedge ck or negedge rst_i) begin
    if (!rst_i) begin
      r_palabra <= '0;
      r_valida  <= 1'b1;
      r_nivel   <= '0;
    end else if (w_acepta) begin
      r_palabra <= r_cand;
      r_valida  <= es_termometro(32'(r_cand), N_NIV);
      r_nivel   <= NW'(popcount(32'(r_cand), N_NIV));
    end
  end

  assign o_palabra = r_palabra;
  assign o_valida  = r_valida;
  assign o_nivel   = r_nivel;

endmodule

// File: rtl/bomba_ctrl_n.sv
// N-pump tank-fill controller: lead/lag rotation, assist pump, minimum-off lockout,
// dry-run timeout and a latched, coded alarm cleared by acknowledge.
module bomba_ctrl_n
  import bomba_pkg::*;
#(
  parameter int N_NIV    = 3,
  parameter int N_BOMBAS = 2,
  parameter int NIV_ARR  = 1,
  parameter int DEB_CYC  = 4,
  parameter int MIN_OFF  = 16,
  parameter int T_AYUDA  = 50,
  parameter int T_SECO   = 100
) (
  input  logic                       ck,
  input  logic                       rst_i,
  input  logic [N_NIV-1:0]           sensores_i,
  input  logic                       ack_i,
  output logic [N_BOMBAS-1:0]        bomba_o,
  output logic                       alarma_o,
  output logic [1:0]                 codigo_o,
  output logic [$clog2(N_NIV+1)-1:0] nivel_o
);

  localparam int CNT_W = $clog2(max3(T_SECO, MIN_OFF, DEB_CYC) + 1);
  localparam int NW    = $clog2(N_NIV + 1);
  localparam int LW    = (N_BOMBAS > 1) ? $clog2(N_BOMBAS) : 1;

  localparam logic [CNT_W-1:0] C_AYUDA = CNT_W'(T_AYUDA);
  localparam logic [CNT_W-1:0] C_SECO  = CNT_W'(T_SECO);
  // The lockout counter starts at 1 on entry and the one REPOSO cycle before a
  // restart is also pump-off time, so leaving at MIN_OFF-1 gives MIN_OFF off cycles.
  localparam logic [CNT_W-1:0] C_ESP   = CNT_W'(MIN_OFF - 1);
  localparam logic [CNT_W-1:0] C_SAT   = {CNT_W{1'b1}};

  estado_t             r_estado;
  logic [LW-1:0]       r_lider;
  logic [CNT_W-1:0]    r_prog;
  logic [CNT_W-1:0]    r_espera;
  logic [NW-1:0]       r_nivel_ant;
  logic [N_BOMBAS-1:0] r_bomba;
  logic                r_alarma;
  logic [1:0]          r_codigo;

  estado_t             w_estado_sig;
  logic [LW-1:0]       w_lider_sig;
  logic [CNT_W-1:0]    w_prog_sig;
  logic [CNT_W-1:0]    w_espera_sig;
  logic [N_BOMBAS-1:0] w_bomba_sig;
  logic                w_alarma_sig;
  logic [1:0]          w_codigo_sig;

  logic [N_NIV-1:0]    w_palabra;
  logic                w_valida;
  logic [NW-1:0]       w_nivel;
  logic [LW-1:0]       w_lag;
  logic [N_BOMBAS-1:0] w_lider_oh;
  logic [N_BOMBAS-1:0] w_lag_oh;
  logic                w_arranque;
  logic                w_lleno;
  logic                w_sube;

  sensor_filtro #(
    .N_NIV  (N_NIV),
    .DEB_CYC(DEB_CYC),
    .CNT_W  (CNT_W)
  ) u_filtro (
    .ck        (ck),
    .rst_i     (rst_i),
    .i_sensores(sensores_i),
    .o_palabra (w_palabra),
    .o_valida  (w_valida),
    .o_nivel   (w_nivel)
  );

  // Lag pump is the next one after the lead, wrapping at N_BOMBAS.
  assign w_lag      = (r_lider == LW'(N_BOMBAS - 1)) ? '0 : r_lider + 1'b1;
  assign w_lider_oh = N_BOMBAS'(1) << r_lider;
  assign w_lag_oh   = N_BOMBAS'(1) << w_lag;
  assign w_arranque = int'(w_nivel) < NIV_ARR;
  assign w_lleno    = &w_palabra;
  assign w_sube     = w_nivel > r_nivel_ant;

  // Next-state, timer and registered-output logic; priority invalid > dry > full > start.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned (no latch).
    w_estado_sig = r_estado;
    w_lider_sig  = r_lider;
    w_prog_sig   = r_prog;
    w_espera_sig = r_espera;
    w_bomba_sig  = '0;
    w_alarma_sig = r_alarma;
    w_codigo_sig = r_codigo;

    case (r_estado)
      REPOSO: begin
        if (!w_valida) begin
          w_estado_sig = FALLA;
          w_alarma_sig = 1'b1;
          w_codigo_sig = COD_INVALIDO;
        end else if (w_arranque) begin
          w_estado_sig = BOMBEO;
          w_prog_sig   = '0;
          w_bomba_sig  = w_lider_oh;
        end
      end

      BOMBEO: begin
        if (!w_valida) begin
          w_estado_sig = FALLA;
          w_alarma_sig = 1'b1;
          w_codigo_sig = COD_INVALIDO;
        end else if (r_prog == C_SECO) begin
          w_estado_sig = FALLA;
          w_alarma_sig = 1'b1;
          w_codigo_sig = COD_SECO;
        end else if (w_lleno) begin
          w_estado_sig = ESPERA;
          w_lider_sig  = w_lag;
          w_espera_sig = CNT_W'(1);
        end else begin
          if (w_sube) w_prog_sig = '0;
          else if (r_prog != C_SAT) w_prog_sig = r_prog + 1'b1;
          w_bomba_sig = w_lider_oh;
          if (N_BOMBAS > 1 && w_prog_sig >= C_AYUDA) w_bomba_sig = w_lider_oh | w_lag_oh;
        end
      end

      ESPERA: begin
        if (!w_valida) begin
          w_estado_sig = FALLA;
          w_alarma_sig = 1'b1;
          w_codigo_sig = COD_INVALIDO;
        end else if (r_espera >= C_ESP) begin
          w_estado_sig = REPOSO;
        end else begin
          w_espera_sig = r_espera + 1'b1;
        end
      end

      FALLA: begin
        // The first fault code is held; only a valid word plus ack releases it.
        if (w_valida && ack_i) begin
          w_estado_sig = ESPERA;
          w_espera_sig = CNT_W'(1);
          w_alarma_sig = 1'b0;
          w_codigo_sig = COD_NINGUNO;
        end
      end

      default: begin
        w_estado_sig = REPOSO;
      end
    endcase
  end

  // State, lead pointer, timers and output registers.
  always_ff @(posedge ck or negedge rst_i) begin
    if (!rst_i) begin
      r_estado    <= REPOSO;
      r_lider     <= '0;
      r_prog      <= '0;
      r_espera    <= '0;
      r_nivel_ant <= '0;
      r_bomba     <= '0;
      r_alarma    <= 1'b0;
      r_codigo    <= COD_NINGUNO;
    end else begin
      r_estado    <= w_estado_sig;
      r_lider     <= w_lider_sig;
      r_prog      <= w_prog_sig;
      r_espera    <= w_espera_sig;
      r_nivel_ant <= w_nivel;
      r_bomba     <= w_bomba_sig;
      r_alarma    <= w_alarma_sig;
      r_codigo    <= w_codigo_sig;
    end
  end

  assign bomba_o  = r_bomba;
  assign alarma_o = r_alarma;
  assign codigo_o = r_codigo;
  assign nivel_o  = w_nivel;

endmodule

// File: tb/tb_bomba_ctrl_n.sv
// Directed bench for bomba_ctrl_n: fill, lockout, assist, dry-run, invalid pattern,
// glitch rejection and asynchronous reset, with hand-computed expectations.
module tb_bomba_ctrl_n;

  logic       ck = 1'b0;
  logic       rst_i = 1'b0;
  logic [2:0] sensores_i = 3'b000;
  logic       ack_i = 1'b0;
  logic [1:0] bomba_o;
  logic       alarma_o;
  logic [1:0] codigo_o;
  logic [1:0] nivel_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ck = ~ck;

  bomba_ctrl_n #(
    .N_NIV   (3),
    .N_BOMBAS(2),
    .NIV_ARR (1),
    .DEB_CYC (4),
    .MIN_OFF (16),
    .T_AYUDA (50),
    .T_SECO  (100)
  ) dut (
    .ck        (ck),
    .rst_i     (rst_i),
    .sensores_i(sensores_i),
    .ack_i     (ack_i),
    .bomba_o   (bomba_o),
    .alarma_o  (alarma_o),
    .codigo_o  (codigo_o),
    .nivel_o   (nivel_o)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held: everything at zero.
    #12;
    check("rst_bomba", 8'(bomba_o), 8'h0);
    check("rst_alarma", 8'(alarma_o), 8'h0);
    check("rst_codigo", 8'(codigo_o), 8'h0);
    check("rst_nivel", 8'(nivel_o), 8'h0);
    rst_i = 1'b1;

    // Empty tank after reset: lead pump 0 starts on the first edge.
    tick(1);
    check("start_bomba", 8'(bomba_o), 8'h1);

    // Fill cycle, one sensor step every 20 cycles; latency is 2 + DEB_CYC = 6.
    tick(19);
    sensores_i = 3'b001;
    tick(5);
    check("lat_pre_nivel", 8'(nivel_o), 8'h0);
    tick(1);
    check("lat_post_nivel", 8'(nivel_o), 8'h1);
    check("fill1_bomba", 8'(bomba_o), 8'h1);
    tick(14);
    sensores_i = 3'b011;
    tick(20);
    check("fill2_nivel", 8'(nivel_o), 8'h2);
    check("fill2_bomba", 8'(bomba_o), 8'h1);
    sensores_i = 3'b111;
    tick(6);
    check("full_nivel", 8'(nivel_o), 8'h3);
    check("full_pre_bomba", 8'(bomba_o), 8'h1);
    tick(1);
    check("full_stop_bomba", 8'(bomba_o), 8'h0);

    // Lockout: drop to empty immediately; pumps stay off exactly 16 cycles.
    sensores_i = 3'b000;
    tick(15);
    check("lock_hold_bomba", 8'(bomba_o), 8'h0);
    tick(1);
    check("lock_restart_lead1", 8'(bomba_o), 8'h2);

    // Assist at 50 cycles of no progress, dry-run fault at 100.
    tick(45);
    check("assist_pre_bomba", 8'(bomba_o), 8'h2);
    tick(10);
    check("assist_bomba", 8'(bomba_o), 8'h3);
    tick(40);
    check("dry_pre_bomba", 8'(bomba_o), 8'h3);
    check("dry_pre_alarma", 8'(alarma_o), 8'h0);
    tick(10);
    check("dry_alarma", 8'(alarma_o), 8'h1);
    check("dry_codigo", 8'(codigo_o), 8'h2);
    check("dry_bomba", 8'(bomba_o), 8'h0);

    // Acknowledge the dry-run fault with a valid word.
    ack_i = 1'b1;
    tick(1);
    check("dry_ack_alarma", 8'(alarma_o), 8'h0);
    check("dry_ack_codigo", 8'(codigo_o), 8'h0);
    ack_i = 1'b0;

    // Invalid pattern during lockout raises code 01.
    sensores_i = 3'b101;
    tick(10);
    check("inv_alarma", 8'(alarma_o), 8'h1);
    check("inv_codigo", 8'(codigo_o), 8'h1);
    check("inv_bomba", 8'(bomba_o), 8'h0);
    ack_i = 1'b1;
    tick(4);
    check("inv_ack_alarma", 8'(alarma_o), 8'h1);
    check("inv_ack_codigo", 8'(codigo_o), 8'h1);
    ack_i = 1'b0;
    sensores_i = 3'b011;
    tick(10);
    check("inv_fixed_alarma", 8'(alarma_o), 8'h1);
    check("inv_fixed_nivel", 8'(nivel_o), 8'h2);
    ack_i = 1'b1;
    tick(1);
    check("inv_clear_alarma", 8'(alarma_o), 8'h0);
    check("inv_clear_codigo", 8'(codigo_o), 8'h0);
    ack_i = 1'b0;

    // Glitch rejection: a 2-cycle 011 pulse on top of 001 never reaches nivel_o.
    sensores_i = 3'b001;
    tick(10);
    check("glitch_base_nivel", 8'(nivel_o), 8'h1);
    sensores_i = 3'b011;
    tick(2);
    sensores_i = 3'b001;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("glitch_nivel", 8'(nivel_o), 8'h1);
    end
    check("glitch_bomba", 8'(bomba_o), 8'h0);

    // Restart pumping (lead still 1), then reset asynchronously mid-BOMBEO.
    sensores_i = 3'b000;
    for (int i = 0; i < 40 && bomba_o == 2'b00; i++) tick(1);
    check("pre_rst_bomba", 8'(bomba_o), 8'h2);
    sensores_i = 3'b001;
    tick(7);
    check("pre_rst_nivel", 8'(nivel_o), 8'h1);
    check("pre_rst_bomba2", 8'(bomba_o), 8'h2);
    #3;
    rst_i = 1'b0;
    #1;
    check("async_rst_bomba", 8'(bomba_o), 8'h0);
    check("async_rst_alarma", 8'(alarma_o), 8'h0);
    check("async_rst_codigo", 8'(codigo_o), 8'h0);
    check("async_rst_nivel", 8'(nivel_o), 8'h0);
    #2;
    rst_i = 1'b1;
    tick(1);
    check("post_rst_lead0", 8'(bomba_o), 8'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bomba_ctrl_n.md
# bomba_ctrl_n

Parametrised tank-fill pump controller, successor to the single-pump `bomba1` generation. It handles N thermometer-coded level sensors and N pumps with lead/lag rotation, assist pump, minimum-off lockout, dry-run timeout and a latched, coded alarm with acknowledge. It sits inside the `tt_um_*` top, fed from raw `uio_in` sensor pins, and drives pump and alarm pins.

## Interface
Parameters:
- `N_NIV`, default 3: number of level sensors. Bit 0 is the lowest sensor.
- `N_BOMBAS`, default 2: number of pumps (≥1).
- `NIV_ARR`, default 1: pumping starts when level < `NIV_ARR`.
- `DEB_CYC`, default 4: cycles a synchronised sensor word must stay stable before it is accepted.
- `MIN_OFF`, default 16: lockout cycles after any stop.
- `T_AYUDA`, default 50: no-progress cycles before the lag pump is added.
- `T_SECO`, default 100: no-progress cycles before the dry-run fault. `T_SECO` > `T_AYUDA`.

Ports:
- `ck` in 1: clock.
- `rst_i` in 1: reset. Asynchronous, active-low.
- `sensores_i` in `N_NIV`: raw, asynchronous level sensors.
- `ack_i` in 1: alarm acknowledge, level-sensitive.
- `bomba_o` out `N_BOMBAS`: pump enables.
- `alarma_o` out 1: fault flag, latched.
- `codigo_o` out 2: fault code. 00 none, 01 invalid sensor pattern, 10 dry-run timeout.
- `nivel_o` out `$clog2(N_NIV+1)`: filtered level, equal to the count of asserted thermometer bits.

## Operation
Sensor front end:
- 2-flop synchroniser feeds a debounce counter.
- The word is accepted once it has been equal for `DEB_CYC` consecutive cycles.
- An accepted word must be thermometer code (a contiguous run of 1s from bit 0). Any other word raises the invalid flag.

FSM:
- REPOSO (pumps off) → BOMBEO when `nivel_o` < `NIV_ARR` and the word is valid.
- BOMBEO:
  - Lead pump on.
  - The progress counter clears on every increase of `nivel_o`.
  - Counter ≥ `T_AYUDA`: the lag pump, (lead+1) mod `N_BOMBAS`, is also on. No lag pump when `N_BOMBAS`=1.
  - `nivel_o` == `N_NIV` → ESPERA. Lead rotates to (lead+1) mod `N_BOMBAS`.
  - Counter == `T_SECO` → FALLA with code 10.
- ESPERA: pumps off for `MIN_OFF` cycles, then → REPOSO. A start request during ESPERA is ignored until the lockout expires.
- FALLA:
  - Pumps off, `alarma_o`=1, `codigo_o` holds the first fault code.
  - Exits to ESPERA when `ack_i`=1 and the current word is valid.
  - `ack_i` while the pattern is still invalid keeps the controller in FALLA.
- Invalid pattern in any state → FALLA with code 01.

Priority in the same cycle: invalid > dry-run timeout > full > start.

Counters saturate and never wrap. Width is `$clog2(max(T_SECO,MIN_OFF,DEB_CYC)+1)`.

## Timing
- Reset values: `bomba_o`=0, `alarma_o`=0, `codigo_o`=00, `nivel_o`=0, state REPOSO, lead=0, all counters 0, synchroniser flops 0.
- Sensor latency: from a pin change to an updated `nivel_o` is 2 + `DEB_CYC` cycles.
- All outputs are registered and change one cycle after the state transition that causes them.
- Start: `bomba_o` rises one cycle after REPOSO→BOMBEO is decided.
- Stop: on full or fault, `bomba_o` clears in the cycle after the decision, with no minimum-on time.
- Reset asserted mid-operation clears everything immediately, regardless of `ck`. Deassertion is synchronised externally.

## Structure
- Package `bomba_pkg` holds:
  - the state enum (REPOSO, BOMBEO, ESPERA, FALLA);
  - the fault-code constants (`COD_NINGUNO`, `COD_INVALIDO`, `COD_SECO`);
  - a `es_termometro` function;
  - a `popcount` function.
- One sub-module, `sensor_filtro`, contains the synchroniser, debounce and validity check. It outputs the accepted word, the valid flag and `nivel_o`.
- `bomba_ctrl_n` contains the FSM, timers, lead pointer and output registers.

## Test plan
All scenarios use `N_NIV`=3, `N_BOMBAS`=2, `DEB_CYC`=4, `MIN_OFF`=16, `T_AYUDA`=50, `T_SECO`=100.
- Fill cycle: `sensores_i`=000, then 001, 011, 111 every 20 cycles → `bomba_o`=01, then 00 within 7 cycles of 111. The next fill drives `bomba_o`=10.
- Assist: start at 000 and hold it → `bomba_o`=11 at 50 cycles of no progress. At 100 cycles: `alarma_o`=1, `codigo_o`=10, `bomba_o`=00.
- Invalid pattern: 101 held ≥6 cycles → FALLA with `codigo_o`=01. `ack_i`=1 with 101 still present → stays in FALLA. Change to 011, then `ack_i` → alarm clears, 16-cycle lockout follows.
- Glitch rejection: 001 → 011 for 2 cycles → back to 001 → `nivel_o` stays 1.
- Lockout: return to 000 immediately after full → `bomba_o` stays 00 for exactly 16 cycles, then restarts.
- Reset: assert `rst_i`=0 mid-BOMBEO, asynchronously to `ck` → all outputs 0 at once, lead=0.
